// File: rtl/sram_responder.sv
// -----------------------------------------------------------------------------
// sram_responder
//   Data-memory responder behind the MEM stage request interface. A read or
//   write request is accepted in IDLE and then held in BUSY for WAIT_CYCLES
//   cycles. The block spends one cycle in DONE, where the access completes,
//   and then returns to IDLE. While an access is in flight, ready is low. The
//   pipeline uses ~ready to freeze.
//
//   Configuration macro: SRAM_RANGE_CHECK_EN
//     When defined, the block adds the range_err output. Accesses outside
//     [BASE_ADDR, BASE_ADDR + 4*MEM_WORDS) have their write suppressed, and
//     reads from those addresses return 0. range_err pulses in the DONE cycle.
//     When undefined, the word index wraps modulo MEM_WORDS.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   mem_r_en  in   read request (level, held until ready)
//   mem_w_en  in   write request (level, held until ready)
//   address   in   byte address, bits [1:0] ignored
//   wr_data   in   write data, sampled at acceptance
//   rd_data   out  read data, valid in DONE and held afterwards
//   ready     out  1 = idle with no request, or access completing
//   range_err out  (macro only) out-of-range access, DONE cycle only
// -----------------------------------------------------------------------------
module sram_responder #(
  parameter int BIT_NUMBER  = 32,
  parameter int MEM_WORDS   = 64,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_r_en,
  input  logic                  mem_w_en,
  input  logic [BIT_NUMBER-1:0] address,
  input  logic [BIT_NUMBER-1:0] wr_data,
  output logic [BIT_NUMBER-1:0] rd_data,
  output logic                  ready
`ifdef SRAM_RANGE_CHECK_EN
  ,
  output logic                  range_err
`endif
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]      CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]      CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [BIT_NUMBER-1:0] BASE_C   = BIT_NUMBER'(BASE_ADDR);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [CNT_W-1:0]        cnt_r;
  logic                    op_wr_r;
  logic [IDX_W-1:0]        idx_r;
  logic [BIT_NUMBER-1:0]   wdata_r;
  logic                    oob_r;
  logic [BIT_NUMBER-1:0]   rd_data_r;
  logic                    range_err_r;
  logic [BIT_NUMBER-1:0]   mem_r [MEM_WORDS];

  logic                    req_s;
  logic                    accept_s;
  logic                    commit_s;
  logic                    ready_s;
  logic                    oob_s;
  logic [BIT_NUMBER-1:0]   addr_off_s;
  logic [IDX_W-1:0]        idx_s;
  logic                    unused_addr_s;

  assign req_s      = mem_r_en | mem_w_en;
  assign addr_off_s = address - BASE_C;
  assign idx_s      = addr_off_s[IDX_W+1:2];
  // Byte-offset bits and the bits above the index do not take part in addressing.
  assign unused_addr_s = ^{addr_off_s[BIT_NUMBER-1:IDX_W+2], addr_off_s[1:0]};

`ifdef SRAM_RANGE_CHECK_EN
  localparam logic [BIT_NUMBER-1:0] LIMIT_C = BIT_NUMBER'(BASE_ADDR + 4 * MEM_WORDS);
  assign oob_s     = (address < BASE_C) || (address >= LIMIT_C);
  assign range_err = range_err_r;
`else
  assign oob_s = 1'b0;
`endif

  assign accept_s = (state_r == ST_IDLE) && req_s;
  // The last BUSY cycle is the edge at which the array is written or read.
  assign commit_s = (state_r == ST_BUSY) && (cnt_r == CNT_ZERO);

  assign rd_data = rd_data_r;
  assign ready   = ready_s;

  // Next-state and ready decode. ready drops in the same cycle a request is accepted.
  always_comb begin
    state_nxt_s = state_r;
    ready_s     = 1'b1;
    case (state_r)
      ST_IDLE: begin
        if (req_s) begin
          state_nxt_s = ST_BUSY;
          ready_s     = 1'b0;
        end else begin
          state_nxt_s = ST_IDLE;
          ready_s     = 1'b1;
        end
      end
      ST_BUSY: begin
        ready_s = 1'b0;
        if (cnt_r == CNT_ZERO) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
        ready_s     = 1'b1;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        ready_s     = 1'b1;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Request latch and wait-state counter. Inputs are only sampled at acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r   <= CNT_ZERO;
      op_wr_r <= 1'b0;
      idx_r   <= {IDX_W{1'b0}};
      wdata_r <= {BIT_NUMBER{1'b0}};
      oob_r   <= 1'b0;
    end else if (accept_s) begin
      cnt_r   <= CNT_LOAD;
      // If both enables are set, the request is treated as a read.
      op_wr_r <= mem_w_en & ~mem_r_en;
      idx_r   <= idx_s;
      wdata_r <= wr_data;
      oob_r   <= oob_s;
    end else if ((state_r == ST_BUSY) && (cnt_r != CNT_ZERO)) begin
      cnt_r <= cnt_r - CNT_ONE;
    end
  end

  // Read data register and range error pulse. Both update only at the commit edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_r   <= {BIT_NUMBER{1'b0}};
      range_err_r <= 1'b0;
    end else begin
      range_err_r <= commit_s && oob_r;
      if (commit_s && !op_wr_r) begin
        rd_data_r <= oob_r ? {BIT_NUMBER{1'b0}} : mem_r[idx_r];
      end
    end
  end

  // Storage array. It is not reset. Writes commit only at the commit edge.
  always_ff @(posedge clk) begin
    if (commit_s && op_wr_r && !oob_r && !rst) begin
      mem_r[idx_r] <= wdata_r;
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// -----------------------------------------------------------------------------
// tb_sram_responder
//   Directed self-checking bench for sram_responder with default parameters.
//   Define SRAM_RANGE_CHECK_EN to exercise the range-checked build.
// -----------------------------------------------------------------------------
module tb_sram_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_r_en = 1'b0;
  logic        mem_w_en = 1'b0;
  logic [31:0] address = 32'd0;
  logic [31:0] wr_data = 32'd0;
  logic [31:0] rd_data;
  logic        ready;
  logic        range_err_s;

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk = ~clk;

  sram_responder dut (
    .clk      (clk),
    .rst      (rst),
    .mem_r_en (mem_r_en),
    .mem_w_en (mem_w_en),
    .address  (address),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .ready    (ready)
`ifdef SRAM_RANGE_CHECK_EN
    ,
    .range_err(range_err_s)
`endif
  );

`ifndef SRAM_RANGE_CHECK_EN
  assign range_err_s = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // One access. Request is driven shortly after a rising edge. The number of
  // ready-low cycles is counted at falling edges, and the result is captured in
  // the DONE cycle. With keep=1 the enables stay high for a back-to-back access.
  task automatic access(input string tag, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d, input bit keep,
                        output logic [31:0] rd, output logic re);
    int low;
    bit seen;
    @(posedge clk); #1;
    mem_r_en = r; mem_w_en = w; address = a; wr_data = d;
    low = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (ready) seen = 1'b1;
      else low++;
    end
    check({tag, "_lat"}, low, 32'd6);
    rd = rd_data;
    re = range_err_s;
    if (!keep) begin
      @(posedge clk); #1;
      mem_r_en = 1'b0; mem_w_en = 1'b0;
    end
  endtask

  logic [31:0] rd;
  logic        re;
  int          low;

  initial begin
    // Reset state
    #2;
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_range_err", {31'd0, range_err_s}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1. write then read
    access("t1_wr", 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 1'b0, rd, re);
    check("t1_wr_re", {31'd0, re}, 32'd0);
    access("t1_rd", 1'b1, 1'b0, 32'd1024, 32'h0, 1'b0, rd, re);
    check("t1_rd_data", rd, 32'hDEADBEEF);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t1_rd_hold", rd_data, 32'hDEADBEEF);

    // 2. back-to-back writes with request held, then readback
    access("t2_wa", 1'b0, 1'b1, 32'd1028, 32'h11, 1'b1, rd, re);
    access("t2_wb", 1'b0, 1'b1, 32'd1032, 32'h22, 1'b0, rd, re);
    access("t2_ra", 1'b1, 1'b0, 32'd1028, 32'h0, 1'b0, rd, re);
    check("t2_ra_data", rd, 32'h11);
    access("t2_rb", 1'b1, 1'b0, 32'd1032, 32'h0, 1'b0, rd, re);
    check("t2_rb_data", rd, 32'h22);

    // 3. request withdrawn mid-access; write still commits
    access("t3_w55", 1'b0, 1'b1, 32'd1024, 32'h55, 1'b0, rd, re);
    @(posedge clk); #1;
    mem_w_en = 1'b1; address = 32'd1024; wr_data = 32'h77;
    @(negedge clk);
    check("t3_accept_ready", {31'd0, ready}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_w_en = 1'b0; address = 32'd1040; wr_data = 32'h0;
    low = 2;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready) break;
      low++;
    end
    check("t3_lat", low, 32'd6);
    access("t3_rd", 1'b1, 1'b0, 32'd1024, 32'h0, 1'b0, rd, re);
    check("t3_rd_data", rd, 32'h77);

    // 4. reset during BUSY of a write discards it
    access("t4_w44", 1'b0, 1'b1, 32'd1036, 32'h44, 1'b0, rd, re);
    access("t4_r44", 1'b1, 1'b0, 32'd1036, 32'h0, 1'b0, rd, re);
    check("t4_r44_data", rd, 32'h44);
    @(posedge clk); #1;
    mem_w_en = 1'b1; address = 32'd1036; wr_data = 32'h99;
    repeat (3) @(posedge clk);
    #1;
    mem_w_en = 1'b0;
    rst = 1'b1;
    #1;
    check("t4_rst_ready", {31'd0, ready}, 32'd1);
    check("t4_rst_rd_data", rd_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    access("t4_rd", 1'b1, 1'b0, 32'd1036, 32'h0, 1'b0, rd, re);
    check("t4_rd_data", rd, 32'h44);

    // 5. both enables: treated as a read, no write
    access("t5_wr", 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 1'b0, rd, re);
    access("t5_both", 1'b1, 1'b1, 32'd1024, 32'h0, 1'b0, rd, re);
    check("t5_both_data", rd, 32'hDEADBEEF);
    access("t5_rd", 1'b1, 1'b0, 32'd1024, 32'h0, 1'b0, rd, re);
    check("t5_rd_data", rd, 32'hDEADBEEF);

    // 6. address one array-size above base
    access("t6_wr", 1'b0, 1'b1, 32'd1280, 32'hAB, 1'b0, rd, re);
`ifdef SRAM_RANGE_CHECK_EN
    check("t6_wr_re", {31'd0, re}, 32'd1);
    @(negedge clk);
    check("t6_re_clear", {31'd0, range_err_s}, 32'd0);
    access("t6_rd_base", 1'b1, 1'b0, 32'd1024, 32'h0, 1'b0, rd, re);
    check("t6_rd_base_data", rd, 32'hDEADBEEF);
    check("t6_rd_base_re", {31'd0, re}, 32'd0);
    access("t6_rd_oob", 1'b1, 1'b0, 32'd1280, 32'h0, 1'b0, rd, re);
    check("t6_rd_oob_data", rd, 32'd0);
    check("t6_rd_oob_re", {31'd0, re}, 32'd1);
`else
    access("t6_rd_wrap", 1'b1, 1'b0, 32'd1024, 32'h0, 1'b0, rd, re);
    check("t6_rd_wrap_data", rd, 32'hAB);
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
